// File: rtl/product_bcd_pkg.sv
// Shared types and constants for the binary-to-BCD product display.
// Holds the FSM state type, segment table and double-dabble helpers.
package product_bcd_pkg;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  localparam int DIGIT_W = 4;
  localparam int ITERS   = 8;

  // Index 0 sits at the LSB end; bit order per entry is {g,f,e,d,c,b,a}.
  localparam logic [9:0][6:0] SEG_TABLE = {
    7'h6F, 7'h7F, 7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

  function automatic logic [3*DIGIT_W-1:0] dabble_adjust(input logic [3*DIGIT_W-1:0] s);
    logic [3*DIGIT_W-1:0] r;
    r = s;
    for (int i = 0; i < 3; i++) begin
      if (s[i*DIGIT_W +: DIGIT_W] >= 4'd5)
        r[i*DIGIT_W +: DIGIT_W] = s[i*DIGIT_W +: DIGIT_W] + 4'd3;
    end
    return r;
  endfunction

endpackage

// File: rtl/seg7_decoder.sv
// Single-digit BCD to seven-segment decoder with blanking.
// Non-decimal codes also go dark.
module seg7_decoder
  import product_bcd_pkg::*;
(
  input  logic [DIGIT_W-1:0] digit,
  input  logic               blank,
  output logic [6:0]         seg
);

  always_comb begin
    seg = '0;
    if (!blank && digit <= 4'd9)
      seg = SEG_TABLE[digit];
  end

endmodule

// File: rtl/product_bcd_display.sv
// Converts an 8-bit product to three BCD digits by double-dabble and
// scans them onto a multiplexed seven-segment display.
module product_bcd_display
  import product_bcd_pkg::*;
#(
  parameter int SCAN_DIV = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  prod_in,
  input  logic        prod_valid,
  output logic        prod_ready,
  output logic [11:0] bcd_out,
  output logic        bcd_valid,
  output logic [6:0]  seg_out,
  output logic [2:0]  dig_sel
);

  localparam logic [15:0] LAST_TICK = 16'(SCAN_DIV - 1);
  localparam logic [2:0]  LAST_STEP = 3'(ITERS - 1);

  state_t       state, state_nx;
  logic [7:0]   bin, bin_nx;
  logic [11:0]  scratch, scratch_nx;
  logic [2:0]   cnt;
  logic [15:0]  presc;
  logic [3:0]   cur_digit;
  logic         cur_blank;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (prod_valid) state_nx = SHIFT;
      SHIFT:   if (cnt == LAST_STEP) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign prod_ready = (state == IDLE);
  assign bcd_valid  = (state == DONE);

  // One dabble step: adjust digits first, then shift the whole chain.
  always_comb begin
    {scratch_nx, bin_nx} = {dabble_adjust(scratch), bin} << 1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bin     <= '0;
      scratch <= '0;
      cnt     <= '0;
      bcd_out <= '0;
    end else if (state == IDLE && prod_valid) begin
      bin     <= prod_in;
      scratch <= '0;
      cnt     <= '0;
    end else if (state == SHIFT) begin
      bin     <= bin_nx;
      scratch <= scratch_nx;
      cnt     <= cnt + 3'd1;
      if (cnt == LAST_STEP)
        bcd_out <= scratch_nx;
    end
  end

  // Display scan runs freely regardless of conversion activity.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc   <= '0;
      dig_sel <= 3'b001;
    end else if (presc == LAST_TICK) begin
      presc   <= '0;
      dig_sel <= {dig_sel[1:0], dig_sel[2]};
    end else begin
      presc   <= presc + 16'd1;
    end
  end

  always_comb begin
    cur_digit = bcd_out[3:0];
    cur_blank = 1'b0;
    if (dig_sel[1]) begin
      cur_digit = bcd_out[7:4];
      cur_blank = (bcd_out[11:4] == 8'd0);
    end else if (dig_sel[2]) begin
      cur_digit = bcd_out[11:8];
      cur_blank = (bcd_out[11:8] == 4'd0);
    end
  end

  seg7_decoder u_seg (
    .digit (cur_digit),
    .blank (cur_blank),
    .seg   (seg_out)
  );

endmodule

// File: doc/product_bcd_display.md
PRODUCT_BCD_DISPLAY -- requirements
Module: product_bcd_display

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 1024, clock cycles each display digit is driven (legal range 2..65535).
REQ-002 SHALL have port clk  input  1  single system clock, all state on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port prod_in  input  8  unsigned binary product from the 4x4 multiplier stage (0..255 accepted).
REQ-005 SHALL have port prod_valid  input  1  prod_in valid this cycle.
REQ-006 SHALL have port prod_ready  output  1  block can accept a value (high only in IDLE).
REQ-007 SHALL have port bcd_out  output  12  registered result {hundreds, tens, units}, 4 bits each.
REQ-008 SHALL have port bcd_valid  output  1  one-cycle pulse when bcd_out updates.
REQ-009 SHALL have port seg_out  output  7  active-high segments {g,f,e,d,c,b,a} for the selected digit.
REQ-010 SHALL have port dig_sel  output  3  one-hot active-high digit enable; bit0 units, bit1 tens, bit2 hundreds.

Function
REQ-011 SHALL implement FSM states IDLE, SHIFT, DONE.
REQ-012 In IDLE, prod_valid=1 at a rising edge SHALL load prod_in into the shift register, clear the BCD scratch, zero the iteration count and enter SHIFT.
REQ-013 SHIFT SHALL perform one double-dabble step per cycle: add 3 to each scratch digit >=5, then shift {scratch, binary} left by 1, for exactly 8 cycles.
REQ-014 After the 8th step the FSM SHALL enter DONE for one cycle, and that edge SHALL write bcd_out.
REQ-015 bcd_valid SHALL be high exactly during the DONE cycle; DONE -> IDLE unconditionally.
REQ-016 Latency: accept edge k -> bcd_out new and bcd_valid=1 after edge k+8; prod_ready high again after edge k+9.
REQ-017 prod_valid while prod_ready=0 SHALL be ignored; no value is queued.
REQ-018 bcd_out SHALL hold its last result until the next conversion completes.
REQ-019 A prescaler SHALL count 0..SCAN_DIV-1; on wrap, dig_sel rotates 001->010->100->001.
REQ-020 seg_out SHALL decode the selected digit as 0=3F,1=06,2=5B,3=4F,4=66,5=6D,6=7D,7=07,8=7F,9=6F (hex).
REQ-021 Leading-zero blanking: hundreds digit 0 -> seg_out=00; tens blanked when hundreds and tens are both 0; units never blanked.
REQ-022 seg_out SHALL be combinational from dig_sel and bcd_out; the scan runs continuously, independent of the FSM.

Reset
REQ-023 rst_n low SHALL asynchronously force: state IDLE, bcd_out=000, bcd_valid=0, prescaler=0, dig_sel=001, scratch/shift/count=0.
REQ-024 While reset or in IDLE, prod_ready=1; seg_out shows units '0' (3F) after reset.
REQ-025 Reset asserted mid-conversion SHALL abort it with no bcd_valid pulse and bcd_out=000.

Structure
REQ-026 Package product_bcd_pkg SHALL hold the FSM state type, the 10-entry segment constant table, BCD digit width (4) and iteration count (8).
REQ-027 Segment decode SHALL be the sub-module seg7_decoder (4-bit digit + blank in, 7-bit segments out); all remaining logic in product_bcd_display.

Verification
REQ-028 prod_in=225 (0xE1), valid 1 cycle -> bcd_valid after exactly 9 edges, bcd_out=0x225; scanned seg_out 6D/5B/5B.
REQ-029 prod_in=0 -> bcd_out=0x000; units 3F, tens and hundreds 00.
REQ-030 prod_in=7 then 48 back-to-back (second valid held until ready) -> 0x007 then 0x048, one bcd_valid pulse each; tens 66 not blanked for 48.
REQ-031 prod_in=255 accepted, prod_in=9 pulsed during SHIFT -> only 0x255 produced, no second pulse.
REQ-032 rst_n low at SHIFT step 4 of prod_in=144 -> bcd_out=0x000, no bcd_valid, prod_ready=1 immediately.
REQ-033 SCAN_DIV=4: dig_sel changes every 4 cycles and returns to 001 after 12 cycles.
